vmode_lock_ctrl: RTL and testbench

//  Sequences repeated VSYNC period measurements, classifies each period as PAL or NTSC,
//  and declares a locked video format only after CONFIRM_COUNT consecutive agreeing periods.

---
 rtl/vmode_lock_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_vmode_lock_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vmode_lock_ctrl.sv
// -----------------------------------------------------------------------------
// vmode_lock_ctrl
//
// Measures successive VSYNC periods, classifies each one as PAL or NTSC and
// declares a locked video format once CONFIRM_COUNT consecutive periods agree.
// While locked, every accepted period is re-classified. The lock is dropped on a
// format change or when VSYNC goes missing. The composite sync passthrough is
// forced high unless a format is locked.
//
// Ports
//   clk_in        in   1   system clock
//   rst_in        in   1   asynchronous, active-high reset
//   enable_in     in   1   1 = run detection, 0 = return to IDLE and clear
//   vsync_in      in   1   raw VSYNC (asynchronous to clk_in)
//   csync_in      in   1   raw composite sync
//   csync_out     out  1   csync_in while format_valid, else 1
//   format_type   out  3   000 unknown, 010 NTSC, 100 PAL
//   format_valid  out  1   1 while a format is locked
//   period_out    out  32  cycles between the last two accepted falling edges
//   lost_out      out  1   one-cycle pulse when a lock is dropped by timeout
//   busy_out      out  1   1 in ACQUIRE or MEASURE
// -----------------------------------------------------------------------------
module vmode_lock_ctrl #(
    parameter int CLK_FREQ           = 250_000,
    parameter int NTSC_PAL_THRESHOLD = 18,
    parameter int MIN_PERIOD_MS      = 10,
    parameter int TIMEOUT_MS         = 40,
    parameter int CONFIRM_COUNT      = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        vsync_in,
    input  logic        csync_in,
    output logic        csync_out,
    output logic [2:0]  format_type,
    output logic        format_valid,
    output logic [31:0] period_out,
    output logic        lost_out,
    output logic        busy_out
);

    localparam logic [31:0] THRESH_CNT  = 32'((CLK_FREQ / 1000) * NTSC_PAL_THRESHOLD);
    localparam logic [31:0] MIN_CNT     = 32'((CLK_FREQ / 1000) * MIN_PERIOD_MS);
    localparam logic [31:0] TIMEOUT_CNT = 32'((CLK_FREQ / 1000) * TIMEOUT_MS);

    // Wide enough to hold CONFIRM_COUNT+1, so a CONFIRM_COUNT of 1 cannot wrap.
    localparam int                CONF_W      = $clog2(CONFIRM_COUNT + 2);
    localparam logic [CONF_W-1:0] CONFIRM_VAL = CONF_W'(CONFIRM_COUNT);
    localparam logic [CONF_W-1:0] CONF_ONE    = CONF_W'(1);

    localparam logic [2:0] FMT_NONE = 3'b000;
    localparam logic [2:0] FMT_NTSC = 3'b010;
    localparam logic [2:0] FMT_PAL  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    state_t            state_q,        state_d;
    logic              sync_meta_q,    sync_meta_d;
    logic              sync_cur_q,     sync_cur_d;
    logic              sync_prev_q,    sync_prev_d;
    logic [31:0]       cnt_q,          cnt_d;
    logic [2:0]        cand_q,         cand_d;
    logic [CONF_W-1:0] conf_q,         conf_d;
    logic [2:0]        format_type_q,  format_type_d;
    logic              format_valid_q, format_valid_d;
    logic [31:0]       period_q,       period_d;
    logic              lost_q,         lost_d;

    logic              vs_edge;
    logic [31:0]       cnt_inc;
    logic              accept;
    logic [2:0]        cls;
    logic [CONF_W-1:0] conf_new;

    // Falling edge as seen at the synchronizer output.
    assign vs_edge = sync_prev_q & ~sync_cur_q;
    assign cnt_inc = cnt_q + 32'd1;
    assign accept  = vs_edge && (cnt_inc >= MIN_CNT);
    // A period exactly at the threshold counts as NTSC.
    assign cls     = (cnt_inc > THRESH_CNT) ? FMT_PAL : FMT_NTSC;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d        = state_q;
        sync_meta_d    = vsync_in;
        sync_cur_d     = sync_meta_q;
        sync_prev_d    = sync_cur_q;
        cnt_d          = cnt_q;
        cand_d         = cand_q;
        conf_d         = conf_q;
        format_type_d  = format_type_q;
        format_valid_d = format_valid_q;
        period_d       = period_q;
        lost_d         = 1'b0;
        conf_new       = CONF_ONE;

        if (!enable_in) begin
            // Disable behaves like a synchronous reset and outranks everything.
            state_d        = ST_IDLE;
            sync_meta_d    = 1'b1;
            sync_cur_d     = 1'b1;
            sync_prev_d    = 1'b1;
            cnt_d          = '0;
            cand_d         = FMT_NONE;
            conf_d         = '0;
            format_type_d  = FMT_NONE;
            format_valid_d = 1'b0;
            period_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end

                ST_ACQUIRE: begin
                    // The first edge only starts the measurement; no timeout here.
                    if (vs_edge) begin
                        cnt_d   = '0;
                        state_d = ST_MEASURE;
                    end
                end

                ST_MEASURE, ST_LOCKED: begin
                    // Glitch edges fall through here and leave cnt counting.
                    cnt_d = cnt_inc;
                    if (accept) begin
                        // An accepted edge beats a simultaneous timeout.
                        period_d = cnt_inc;
                        cnt_d    = '0;
                        if (state_q == ST_MEASURE) begin
                            if (cls == cand_q) begin
                                conf_new = conf_q + CONF_ONE;
                            end else begin
                                conf_new = CONF_ONE;
                            end
                            cand_d = cls;
                            conf_d = conf_new;
                            if (conf_new >= CONFIRM_VAL) begin
                                state_d        = ST_LOCKED;
                                format_type_d  = cls;
                                format_valid_d = 1'b1;
                            end
                        end else if (cls != format_type_q) begin
                            // Format changed under lock: re-qualify from scratch,
                            // counting this period as the first vote.
                            state_d        = ST_MEASURE;
                            format_type_d  = FMT_NONE;
                            format_valid_d = 1'b0;
                            cand_d         = cls;
                            conf_d         = CONF_ONE;
                        end
                    end else if (cnt_q == TIMEOUT_CNT - 32'd1) begin
                        state_d        = ST_ACQUIRE;
                        cnt_d          = '0;
                        cand_d         = FMT_NONE;
                        conf_d         = '0;
                        format_type_d  = FMT_NONE;
                        format_valid_d = 1'b0;
                        lost_d         = (state_q == ST_LOCKED);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            sync_meta_q    <= 1'b1;
            sync_cur_q     <= 1'b1;
            sync_prev_q    <= 1'b1;
            cnt_q          <= '0;
            cand_q         <= FMT_NONE;
            conf_q         <= '0;
            format_type_q  <= FMT_NONE;
            format_valid_q <= 1'b0;
            period_q       <= '0;
            lost_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // from before this edge regardless of statement order.
            state_q        <= state_d;
            sync_meta_q    <= sync_meta_d;
            sync_cur_q     <= sync_cur_d;
            sync_prev_q    <= sync_prev_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            conf_q         <= conf_d;
            format_type_q  <= format_type_d;
            format_valid_q <= format_valid_d;
            period_q       <= period_d;
            lost_q         <= lost_d;
        end
    end

    assign format_type  = format_type_q;
    assign format_valid = format_valid_q;
    assign period_out   = period_q;
    assign lost_out     = lost_q;
    assign busy_out     = (state_q == ST_ACQUIRE) || (state_q == ST_MEASURE);
    assign csync_out    = format_valid_q ? csync_in : 1'b1;

endmodule

// File: tb/tb_vmode_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vmode_lock_ctrl
//
// Directed bench for vmode_lock_ctrl with default parameters. All stimulus is
// driven and all outputs sampled 1 ns after a rising clock edge. A falling
// VSYNC edge driven at tick k is registered by the DUT at tick k+3.
// -----------------------------------------------------------------------------
module tb_vmode_lock_ctrl;

    localparam int LOW = 20;   // VSYNC low-pulse width in cycles

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic        vsync_in;
    logic        csync_in;
    logic        csync_out;
    logic [2:0]  format_type;
    logic        format_valid;
    logic [31:0] period_out;
    logic        lost_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;
    int lost_count = 0;

    vmode_lock_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .enable_in    (enable_in),
        .vsync_in     (vsync_in),
        .csync_in     (csync_in),
        .csync_out    (csync_out),
        .format_type  (format_type),
        .format_valid (format_valid),
        .period_out   (period_out),
        .lost_out     (lost_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Counts lost_out pulses, one per cycle it is high.
    always @(posedge clk_in) begin
        if (lost_out === 1'b1) lost_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Next falling edge comes 'gap' cycles after the previous one; returns LOW
    // cycles after the fall, once the DUT has registered it.
    task automatic gap_fall(input int gap);
        tick(gap - LOW);
        vsync_in = 1'b0;
        tick(LOW);
        vsync_in = 1'b1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1; enable_in = 1'b0; vsync_in = 1'b1; csync_in = 1'b0;
        tick(3);
        enable_in = 1'b1;
        tick(2);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", format_valid); end
        total++; if (format_type !== 3'b000) begin bad++; $display("FAIL reset_type: got %b want 000", format_type); end
        total++; if (period_out !== 32'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_out); end
        total++; if (lost_out !== 1'b0) begin bad++; $display("FAIL reset_lost: got %b want 0", lost_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        total++; if (csync_out !== 1'b1) begin bad++; $display("FAIL reset_csync: got %b want 1", csync_out); end
        rst_in = 1'b0;
        tick(1);
    endtask

    task automatic test_ntsc_lock;
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL acquire_busy: got %b want 1", busy_out); end
        gap_fall(LOW);
        gap_fall(4171);
        gap_fall(4171);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL ntsc_early_valid: got %b want 0", format_valid); end
        gap_fall(4171);
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL ntsc_valid: got %b want 1", format_valid); end
        total++; if (format_type !== 3'b010) begin bad++; $display("FAIL ntsc_type: got %b want 010", format_type); end
        total++; if (period_out !== 32'd4171) begin bad++; $display("FAIL ntsc_period: got %0d want 4171", period_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL ntsc_busy: got %b want 0", busy_out); end
    endtask

    task automatic test_min_exact;
        gap_fall(2500);
        total++; if (period_out !== 32'd2500) begin bad++; $display("FAIL min_exact_period: got %0d want 2500", period_out); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL min_exact_valid: got %b want 1", format_valid); end
    endtask

    task automatic test_thresh_ntsc;
        gap_fall(4500);
        total++; if (period_out !== 32'd4500) begin bad++; $display("FAIL thresh4500_period: got %0d want 4500", period_out); end
        total++; if (format_type !== 3'b010) begin bad++; $display("FAIL thresh4500_type: got %b want 010", format_type); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL thresh4500_valid: got %b want 1", format_valid); end
    endtask

    task automatic test_disable;
        csync_in = 1'b0;
        enable_in = 1'b0;
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL disable_same_cycle: got %b want 1", format_valid); end
        tick(1);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL disable_valid: got %b want 0", format_valid); end
        total++; if (format_type !== 3'b000) begin bad++; $display("FAIL disable_type: got %b want 000", format_type); end
        total++; if (period_out !== 32'd0) begin bad++; $display("FAIL disable_period: got %0d want 0", period_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL disable_busy: got %b want 0", busy_out); end
        total++; if (csync_out !== 1'b1) begin bad++; $display("FAIL disable_csync: got %b want 1", csync_out); end
        enable_in = 1'b1;
        tick(1);
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL reenable_busy: got %b want 1", busy_out); end
    endtask

    task automatic test_pal_lock;
        gap_fall(LOW);
        gap_fall(5000);
        gap_fall(5000);
        // Fourth edge by hand to pin down the registration latency.
        tick(5000 - LOW);
        vsync_in = 1'b0;
        tick(2);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL pal_latency_pre: got %b want 0", format_valid); end
        tick(1);
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL pal_valid: got %b want 1", format_valid); end
        total++; if (format_type !== 3'b100) begin bad++; $display("FAIL pal_type: got %b want 100", format_type); end
        total++; if (period_out !== 32'd5000) begin bad++; $display("FAIL pal_period: got %0d want 5000", period_out); end
        tick(LOW - 3);
        vsync_in = 1'b1;
    endtask

    task automatic test_thresh_pal;
        gap_fall(4501);
        total++; if (period_out !== 32'd4501) begin bad++; $display("FAIL thresh4501_period: got %0d want 4501", period_out); end
        total++; if (format_type !== 3'b100) begin bad++; $display("FAIL thresh4501_type: got %b want 100", format_type); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL thresh4501_valid: got %b want 1", format_valid); end
    endtask

    task automatic test_glitch;
        gap_fall(1000);
        total++; if (period_out !== 32'd4501) begin bad++; $display("FAIL glitch1000_period: got %0d want 4501", period_out); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL glitch1000_valid: got %b want 1", format_valid); end
        gap_fall(1499);   // 2499 cycles after the accepted edge: still a glitch
        total++; if (period_out !== 32'd4501) begin bad++; $display("FAIL glitch2499_period: got %0d want 4501", period_out); end
        gap_fall(2301);   // 4800 cycles after the accepted edge
        total++; if (period_out !== 32'd4800) begin bad++; $display("FAIL after_glitch_period: got %0d want 4800", period_out); end
        total++; if (format_type !== 3'b100) begin bad++; $display("FAIL after_glitch_type: got %b want 100", format_type); end
    endtask

    task automatic test_timeout_edge;
        gap_fall(10000);
        total++; if (period_out !== 32'd10000) begin bad++; $display("FAIL timeout_edge_period: got %0d want 10000", period_out); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL timeout_edge_valid: got %b want 1", format_valid); end
        total++; if (lost_count !== 0) begin bad++; $display("FAIL timeout_edge_lost: got %0d want 0", lost_count); end
    endtask

    task automatic test_format_switch;
        gap_fall(4171);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL switch_drop_valid: got %b want 0", format_valid); end
        total++; if (format_type !== 3'b000) begin bad++; $display("FAIL switch_drop_type: got %b want 000", format_type); end
        total++; if (period_out !== 32'd4171) begin bad++; $display("FAIL switch_drop_period: got %0d want 4171", period_out); end
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL switch_drop_busy: got %b want 1", busy_out); end
        total++; if (lost_count !== 0) begin bad++; $display("FAIL switch_drop_lost: got %0d want 0", lost_count); end
        gap_fall(4171);
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL switch_mid_valid: got %b want 0", format_valid); end
        gap_fall(4171);
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL switch_relock_valid: got %b want 1", format_valid); end
        total++; if (format_type !== 3'b010) begin bad++; $display("FAIL switch_relock_type: got %b want 010", format_type); end
    endtask

    task automatic test_csync;
        csync_in = 1'b0;
        #1;
        total++; if (csync_out !== 1'b0) begin bad++; $display("FAIL csync_pass0: got %b want 0", csync_out); end
        csync_in = 1'b1;
        #1;
        total++; if (csync_out !== 1'b1) begin bad++; $display("FAIL csync_pass1: got %b want 1", csync_out); end
        csync_in = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout;
        // Last accepted fall was at tick k; we are now at k+LOW+1 (test_csync ticked once).
        tick(10002 - LOW - 1);
        total++; if (lost_out !== 1'b0) begin bad++; $display("FAIL timeout_pre_lost: got %b want 0", lost_out); end
        total++; if (format_valid !== 1'b1) begin bad++; $display("FAIL timeout_pre_valid: got %b want 1", format_valid); end
        tick(1);
        total++; if (lost_out !== 1'b1) begin bad++; $display("FAIL timeout_lost: got %b want 1", lost_out); end
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL timeout_valid: got %b want 0", format_valid); end
        total++; if (csync_out !== 1'b1) begin bad++; $display("FAIL timeout_csync: got %b want 1", csync_out); end
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL timeout_busy: got %b want 1", busy_out); end
        tick(1);
        total++; if (lost_out !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width: got %b want 0", lost_out); end
        total++; if (lost_count !== 1) begin bad++; $display("FAIL timeout_pulse_count: got %0d want 1", lost_count); end
    endtask

    task automatic test_reset_mid_measure;
        gap_fall(LOW);   // ACQUIRE -> MEASURE
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL measure_busy: got %b want 1", busy_out); end
        total++; if (period_out !== 32'd4171) begin bad++; $display("FAIL measure_period_held: got %0d want 4171", period_out); end
        #3;
        rst_in = 1'b1;
        #1;
        total++; if (period_out !== 32'd0) begin bad++; $display("FAIL async_reset_period: got %0d want 0", period_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b want 0", busy_out); end
        total++; if (format_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b want 0", format_valid); end
        total++; if (format_type !== 3'b000) begin bad++; $display("FAIL async_reset_type: got %b want 000", format_type); end
        tick(2);
        rst_in = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_ntsc_lock();
        test_min_exact();
        test_thresh_ntsc();
        test_disable();
        test_pal_lock();
        test_thresh_pal();
        test_glitch();
        test_timeout_edge();
        test_format_switch();
        test_csync();
        test_timeout();
        test_reset_mid_measure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
